// File: rtl/band_ser_pkg.sv
// band_ser_pkg: shared defaults, state encoding and band slicing helper for band_serializer.
//   No ports. Provides DEF_DW / DEF_NBANDS / DEF_IDXW, the IDLE/SHIFT state
//   enum and band_lo(), the low bit of band k in a flat NBANDS*w bus.
package band_ser_pkg;
   localparam int DEF_DW     = 31;
   localparam int DEF_NBANDS = 13;
   localparam int DEF_IDXW   = 4;

   typedef enum logic {IDLE, SHIFT} state_e;

   function automatic int band_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/band_frame_buf.sv
// band_frame_buf: NBANDS x DW register bank with bus load and indexed band read.
//   clk    in   clock
//   ld_i   in   load enable; bus_i captured on the rising edge
//   bus_i  in   flat frame, band k at [k*DW +: DW]
//   idx_i  in   band index for dat_o
//   dat_o  out  band idx_i of the stored frame
//   bus_o  out  whole stored frame, same layout as bus_i
module band_frame_buf
   import band_ser_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int NBANDS = DEF_NBANDS,
   parameter int IDXW   = DEF_IDXW
) (
   input  logic                 clk,
   input  logic                 ld_i,
   input  logic [NBANDS*DW-1:0] bus_i,
   input  logic [IDXW-1:0]      idx_i,
   output logic [DW-1:0]        dat_o,
   output logic [NBANDS*DW-1:0] bus_o
);
   logic [NBANDS*DW-1:0] mem_q;
   logic [DW-1:0]        band [NBANDS];

   // Contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk)
      if (ld_i) mem_q <= bus_i;

   for (genvar k = 0; k < NBANDS; k++) begin : g_band
      assign band[k] = mem_q[band_lo(k, DW) +: DW];
   end

   assign dat_o = band[idx_i];
   assign bus_o = mem_q;
endmodule

// File: rtl/band_serializer.sv
// band_serializer: captures a frame of NBANDS band sums and streams them out one per beat.
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   din_bus    in   frame, band k at [k*DW +: DW], valid while in_en
//   in_en      in   one-cycle frame load strobe
//   dout       out  current band value
//   dout_idx   out  index of the band on dout
//   out_valid  out  dout/dout_idx valid
//   out_ready  in   downstream accepts the beat
//   out_last   out  high with band NBANDS-1
//   busy       out  streaming or a frame is pending
//   overrun    out  one-cycle pulse when an incoming frame is dropped
//   frame_tag  out  (only with SER_FRAME_TAG_EN) 8-bit count of frames loaded into active
module band_serializer
   import band_ser_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int NBANDS = DEF_NBANDS,
   parameter int IDXW   = DEF_IDXW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NBANDS*DW-1:0] din_bus,
   input  logic                 in_en,
   output logic [DW-1:0]        dout,
   output logic [IDXW-1:0]      dout_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun
`ifdef SER_FRAME_TAG_EN
   ,
   output logic [7:0]           frame_tag
`endif
);
   localparam logic [IDXW-1:0] LAST = IDXW'(NBANDS - 1);

   state_e               state_q, state_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic                 pv_q, pv_d;
   logic                 ovr_q;
   logic                 beat, fin, promote, act_ld, pend_ld, drop;
   logic [NBANDS*DW-1:0] act_src, pend_bus, unused_act_bus;
   logic [DW-1:0]        act_dat, unused_pend_dat;

   always_comb begin
      beat    = (state_q == SHIFT) && out_ready;
      fin     = beat && (idx_q == LAST);
      promote = fin && pv_q;
      // Load active from idle, or directly from din_bus when the last beat
      // leaves with nothing pending; otherwise in_en targets the pending slot.
      act_ld  = promote || (in_en && ((state_q == IDLE) || (fin && !pv_q)));
      act_src = promote ? pend_bus : din_bus;
      pend_ld = in_en && (state_q == SHIFT) && !(fin && !pv_q) && (!pv_q || promote);
      drop    = in_en && (state_q == SHIFT) && pv_q && !promote;
      pv_d    = pend_ld ? 1'b1 : promote ? 1'b0 : pv_q;
      state_d = act_ld ? SHIFT : fin ? IDLE : state_q;
      idx_d   = (act_ld || fin) ? '0 : beat ? idx_q + IDXW'(1) : idx_q;
   end

   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pv_q    <= pv_d;
         ovr_q   <= drop;
      end

   band_frame_buf #(.DW(DW), .NBANDS(NBANDS), .IDXW(IDXW)) u_act (
      .clk   (clk),
      .ld_i  (act_ld),
      .bus_i (act_src),
      .idx_i (idx_q),
      .dat_o (act_dat),
      .bus_o (unused_act_bus)
   );

   band_frame_buf #(.DW(DW), .NBANDS(NBANDS), .IDXW(IDXW)) u_pend (
      .clk   (clk),
      .ld_i  (pend_ld),
      .bus_i (din_bus),
      .idx_i (idx_q),
      .dat_o (unused_pend_dat),
      .bus_o (pend_bus)
   );

   // Every output is a function of registers only; dout is forced to zero
   // outside SHIFT so the don't-care buffer never shows after reset.
   assign out_valid = state_q == SHIFT;
   assign dout      = out_valid ? act_dat : '0;
   assign dout_idx  = idx_q;
   assign out_last  = out_valid && (idx_q == LAST);
   assign busy      = out_valid || pv_q;
   assign overrun   = ovr_q;

`ifdef SER_FRAME_TAG_EN
   logic [7:0] tag_q;

   always_ff @(posedge clk)
      if (rst) tag_q <= '0;
      else if (act_ld) tag_q <= tag_q + 8'd1;

   assign frame_tag = tag_q;
`endif
endmodule

// File: tb/tb_band_serializer.sv
// tb_band_serializer: directed self-checking bench for band_serializer.
module tb_band_serializer;
   localparam int DW = 31;
   localparam int NB = 13;
   localparam int IW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_en = 1'b0;
   logic             out_ready = 1'b0;
   logic [NB*DW-1:0] din_bus = '0;
   logic [DW-1:0]    dout;
   logic [IW-1:0]    dout_idx;
   logic             out_valid, out_last, busy, overrun;
`ifdef SER_FRAME_TAG_EN
   logic [7:0]       frame_tag;
`endif

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   band_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .din_bus   (din_bus),
      .in_en     (in_en),
      .dout      (dout),
      .dout_idx  (dout_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun)
`ifdef SER_FRAME_TAG_EN
      ,
      .frame_tag (frame_tag)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input int base);
      for (int k = 0; k < NB; k++) din_bus[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic load(input int base);
      set_frame(base);
      in_en = 1'b1;
      step();
      in_en = 1'b0;
   endtask

   task automatic beat_chk(input string tag, input int val, input int idx);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_dout"}, 64'(dout), 64'(val));
      chk({tag, "_idx"}, 64'(dout_idx), 64'(idx));
      chk({tag, "_last"}, 64'(out_last), 64'(idx == NB - 1));
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      step();
      step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_idx", 64'(dout_idx), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      rst = 1'b0;

      out_ready = 1'b1;
      load(100);
      for (int k = 0; k < NB; k++) begin
         beat_chk("single", 100 + k, k);
         step();
      end
      idle_chk("single_end");

      load(100);
      for (int c = 0; c < 16; c++) begin
         beat_chk("bp", 100 + (c < 5 ? c : c < 8 ? 5 : c - 3), c < 5 ? c : c < 8 ? 5 : c - 3);
         out_ready = !(c >= 5 && c < 8);
         step();
      end
      idle_chk("bp_end");

      out_ready = 1'b1;
      load(0);
      for (int c = 0; c < 2 * NB; c++) begin
         beat_chk("b2b", c < NB ? c : 1000 + c - NB, c % NB);
         if (c == 4) begin
            set_frame(1000);
            in_en = 1'b1;
         end
         step();
         in_en = 1'b0;
         if (c == 4) chk("b2b_busy_pend", 64'(busy), 64'd1);
      end
      idle_chk("b2b_end");

      out_ready = 1'b0;
      load(32'h10000);
      step();
      load(32'h20000);
      chk("ovr_b_no_pulse", 64'(overrun), 64'd0);
      step();
      load(32'h30000);
      chk("ovr_pulse", 64'(overrun), 64'd1);
      chk("ovr_hold_dout", 64'(dout), 64'h10000);
      step();
      chk("ovr_pulse_end", 64'(overrun), 64'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 2 * NB; c++) begin
         beat_chk("ovr_stream", c < NB ? 32'h10000 + c : 32'h20000 + c - NB, c % NB);
         chk("ovr_quiet", 64'(overrun), 64'd0);
         step();
      end
      idle_chk("ovr_end");

      load(500);
      for (int c = 0; c < 7; c++) begin
         if (c == 2) begin
            set_frame(600);
            in_en = 1'b1;
         end
         step();
         in_en = 1'b0;
      end
      beat_chk("mid_pre", 507, 7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_chk("mid_rst");
      chk("mid_rst_dout", 64'(dout), 64'd0);
      chk("mid_rst_idx", 64'(dout_idx), 64'd0);
      load(700);
      for (int k = 0; k < NB; k++) begin
         beat_chk("mid_fresh", 700 + k, k);
         step();
      end
      idle_chk("mid_end");

`ifdef SER_FRAME_TAG_EN
      rst = 1'b1;
      step();
      chk("tag_rst", 64'(frame_tag), 64'd0);
      rst = 1'b0;
      for (int f = 1; f <= 257; f++) begin
         load(f * 16);
         for (int k = 0; k < NB; k++) begin
            if (k == 0 || k == NB - 1) chk("tag", 64'(frame_tag), 64'(f % 256));
            if (k == 0) chk("tag_dout", 64'(dout), 64'(f * 16));
            step();
         end
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
